// File: rtl/stream_demux_2.sv
// ============================================================================
// Module   : stream_demux_2
// Purpose  : 1-to-2 valid/ready stream demultiplexer with a 2-entry FIFO per output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux_2 #(
  parameter int NrOfBits = 32
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [NrOfBits-1:0] DemuxIn,
  input  logic                Sel,
  input  logic                InValid,
  output logic                InReady,
  output logic [NrOfBits-1:0] DemuxOut_0,
  output logic                OutValid_0,
  input  logic                OutReady_0,
  output logic [NrOfBits-1:0] DemuxOut_1,
  output logic                OutValid_1,
  input  logic                OutReady_1,
  output logic [1:0]          Level_0,
  output logic [1:0]          Level_1
);

  localparam logic [1:0] c_full = 2'd2;

  logic [1:0]                w_push;
  logic [1:0]                w_out_ready;
  logic [1:0][1:0]           w_level;
  logic [1:0][NrOfBits-1:0]  w_head;
  logic                      w_accept;

  // Ready depends only on the selected FIFO so the other output can stall freely.
  assign InReady     = Enable & Reset & (Sel ? (w_level[1] != c_full) : (w_level[0] != c_full));
  assign w_accept    = InValid & InReady;
  assign w_push      = {w_accept & Sel, w_accept & ~Sel};
  assign w_out_ready = {OutReady_1, OutReady_0};

  for (genvar k = 0; k < 2; k++) begin : g_fifo
    logic [NrOfBits-1:0] r_mem0;
    logic [NrOfBits-1:0] r_mem1;
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_level;
    logic                w_pop;

    assign w_pop = (r_level != 2'd0) & w_out_ready[k];

    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        r_mem0   <= '0;
        r_mem1   <= '0;
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_level  <= 2'd0;
      end else begin
        if (w_push[k]) begin
          if (r_wr_ptr) r_mem1 <= DemuxIn;
          else          r_mem0 <= DemuxIn;
          r_wr_ptr <= ~r_wr_ptr;
        end
        if (w_pop) r_rd_ptr <= ~r_rd_ptr;
        // Push and pop together leave the occupancy unchanged.
        case ({w_push[k], w_pop})
          2'b10:   r_level <= r_level + 2'd1;
          2'b01:   r_level <= r_level - 2'd1;
          default: r_level <= r_level;
        endcase
      end
    end

    assign w_level[k] = r_level;
    assign w_head[k]  = r_rd_ptr ? r_mem1 : r_mem0;
  end

  assign DemuxOut_0 = w_head[0];
  assign DemuxOut_1 = w_head[1];
  assign Level_0    = w_level[0];
  assign Level_1    = w_level[1];
  assign OutValid_0 = (w_level[0] != 2'd0);
  assign OutValid_1 = (w_level[1] != 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_2.sv
// ============================================================================
// Module   : tb_stream_demux_2
// Purpose  : Self-checking bench for stream_demux_2 against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_demux_2;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Enable = 1'b0;
  logic [31:0] DemuxIn = '0;
  logic        Sel = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [31:0] DemuxOut_0, DemuxOut_1;
  logic        OutValid_0, OutValid_1;
  logic        OutReady_0 = 1'b0;
  logic        OutReady_1 = 1'b0;
  logic [1:0]  Level_0, Level_1;

  int total = 0;
  int bad   = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  stream_demux_2 #(.NrOfBits(32)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .DemuxIn(DemuxIn), .Sel(Sel),
    .InValid(InValid), .InReady(InReady),
    .DemuxOut_0(DemuxOut_0), .OutValid_0(OutValid_0), .OutReady_0(OutReady_0),
    .DemuxOut_1(DemuxOut_1), .OutValid_1(OutValid_1), .OutReady_1(OutReady_1),
    .Level_0(Level_0), .Level_1(Level_1)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each output is a queue of at most two beats; checked mid-cycle, then advanced.
  always @(negedge Clock) begin
    logic exp_ready, pop0, pop1;
    if (!Reset) begin
      chk("rst_inready", {31'b0, InReady}, 32'd0);
      chk("rst_level0", {30'b0, Level_0}, 32'd0);
      chk("rst_level1", {30'b0, Level_1}, 32'd0);
      chk("rst_valid", {30'b0, OutValid_1, OutValid_0}, 32'd0);
      chk("rst_data0", DemuxOut_0, 32'd0);
      chk("rst_data1", DemuxOut_1, 32'd0);
      q0.delete();
      q1.delete();
    end else begin
      exp_ready = Enable && (Sel ? (q1.size() < 2) : (q0.size() < 2));
      chk("inready", {31'b0, InReady}, {31'b0, exp_ready});
      chk("level0", {30'b0, Level_0}, q0.size());
      chk("level1", {30'b0, Level_1}, q1.size());
      chk("valid0", {31'b0, OutValid_0}, {31'b0, q0.size() != 0});
      chk("valid1", {31'b0, OutValid_1}, {31'b0, q1.size() != 0});
      if (q0.size() != 0) chk("data0", DemuxOut_0, q0[0]);
      if (q1.size() != 0) chk("data1", DemuxOut_1, q1[0]);
      pop0 = (q0.size() != 0) && OutReady_0;
      pop1 = (q1.size() != 0) && OutReady_1;
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (InValid && exp_ready) begin
        if (Sel) q1.push_back(DemuxIn);
        else     q0.push_back(DemuxIn);
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Present a beat and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic s, input logic [31:0] d);
    bit done = 0;
    InValid = 1'b1;
    Sel     = s;
    DemuxIn = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge Clock);
      if (InReady) done = 1;
      step();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept expected accept of %h", d);
    end
    InValid = 1'b0;
  endtask

  initial begin
    logic took;

    // Reset state
    repeat (2) step();
    chk("rst_hold_inready", {31'b0, InReady}, 32'd0);
    Reset  = 1'b1;
    Enable = 1'b1;
    step();
    chk("post_rst_inready", {31'b0, InReady}, 32'd1);

    // Single beats to each port
    OutReady_0 = 1'b1;
    OutReady_1 = 1'b1;
    send(1'b0, 32'h11);
    chk("lit_out0_11", DemuxOut_0, 32'h11);
    chk("lit_valid0", {31'b0, OutValid_0}, 32'd1);
    send(1'b1, 32'h22);
    chk("lit_out1_22", DemuxOut_1, 32'h22);
    step();
    chk("lit_level0_empty", {30'b0, Level_0}, 32'd0);
    chk("lit_level1_empty", {30'b0, Level_1}, 32'd0);

    // Fill output 0; output 1 still accepts
    OutReady_0 = 1'b0;
    send(1'b0, 32'hA1);
    send(1'b0, 32'hA2);
    chk("lit_level0_full", {30'b0, Level_0}, 32'd2);
    InValid = 1'b1; Sel = 1'b0; DemuxIn = 32'hDEAD;
    #1 chk("lit_full_blocks", {31'b0, InReady}, 32'd0);
    InValid = 1'b0;
    send(1'b1, 32'hB1);
    chk("lit_b1_out", DemuxOut_1, 32'hB1);
    OutReady_0 = 1'b1;
    chk("lit_head_a1", DemuxOut_0, 32'hA1);
    step();
    chk("lit_head_a2", DemuxOut_0, 32'hA2);
    step();

    // Simultaneous push and pop at level 1
    OutReady_0 = 1'b0;
    send(1'b0, 32'hC1);
    OutReady_0 = 1'b1;
    send(1'b0, 32'hC2);
    chk("lit_pushpop_level", {30'b0, Level_0}, 32'd1);
    chk("lit_pushpop_head", DemuxOut_0, 32'hC2);
    step();

    // Enable low blocks input but not draining
    OutReady_0 = 1'b0;
    send(1'b0, 32'hE1);
    Enable = 1'b0;
    InValid = 1'b1; Sel = 1'b1; DemuxIn = 32'hE2;
    #1 chk("lit_enable_off", {31'b0, InReady}, 32'd0);
    OutReady_0 = 1'b1;
    repeat (3) step();
    chk("lit_enable_drain", {30'b0, Level_0}, 32'd0);
    chk("lit_enable_nopush", {30'b0, Level_1}, 32'd0);
    InValid = 1'b0;
    Enable  = 1'b1;

    // Asynchronous reset mid-cycle discards buffered beats
    OutReady_0 = 1'b0;
    OutReady_1 = 1'b0;
    send(1'b0, 32'hD1);
    send(1'b0, 32'hD2);
    send(1'b1, 32'hF1);
    #2 Reset = 1'b0;
    #1;
    chk("lit_async_level0", {30'b0, Level_0}, 32'd0);
    chk("lit_async_level1", {30'b0, Level_1}, 32'd0);
    chk("lit_async_valid", {30'b0, OutValid_1, OutValid_0}, 32'd0);
    chk("lit_async_data0", DemuxOut_0, 32'd0);
    step();
    Reset = 1'b1;
    OutReady_0 = 1'b1;
    OutReady_1 = 1'b1;
    repeat (2) step();
    chk("lit_no_stale", {30'b0, OutValid_1, OutValid_0}, 32'd0);

    // Randomized traffic; a presented beat is held until accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clock);
      took = InValid && InReady;
      step();
      if (!InValid || took) begin
        InValid = ($urandom_range(0, 3) != 0);
        Sel     = $urandom_range(0, 1) == 1;
        DemuxIn = $urandom;
      end
      OutReady_0 = ($urandom_range(0, 2) != 0);
      OutReady_1 = ($urandom_range(0, 3) == 0);
      Enable     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 Reset = 1'b0;
        step();
        Reset = 1'b1;
      end
    end

    InValid    = 1'b0;
    Enable     = 1'b1;
    OutReady_0 = 1'b1;
    OutReady_1 = 1'b1;
    repeat (5) step();
    chk("final_empty", {30'b0, Level_1, Level_0}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_demux_2.md
Name: stream_demux_2

Overview:
- Sequential 1-to-2 bus demultiplexer; counterpart of the 2-input bus multiplexer in the MCU plexer library.
- Routes one valid/ready input stream to one of two output streams, selected per beat by Sel.
- Each output has a 2-entry FIFO, so a stalled consumer on one output does not block beats for the other output.
- Used in the MCU to steer bus write data to one of two peripheral ports.

Parameters:
- NrOfBits, 32, data width of input and both outputs.

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset; assertion clears all state immediately.
- Enable  input  1  1 = accept input beats; 0 = InReady forced to 0 while outputs keep draining.
- DemuxIn  input  NrOfBits  input data beat.
- Sel  input  1  destination of the current beat: 0 = output 0, 1 = output 1.
- InValid  input  1  DemuxIn/Sel hold a valid beat.
- InReady  output  1  block accepts the beat this cycle.
- DemuxOut_0  output  NrOfBits  head data of FIFO 0.
- OutValid_0  output  1  FIFO 0 not empty.
- OutReady_0  input  1  consumer 0 accepts the head.
- DemuxOut_1  output  NrOfBits  head data of FIFO 1.
- OutValid_1  output  1  FIFO 1 not empty.
- OutReady_1  input  1  consumer 1 accepts the head.
- Level_0  output  2  FIFO 0 occupancy, 0..2.
- Level_1  output  2  FIFO 1 occupancy, 0..2.

Behaviour:
- Reset (Reset=0, asynchronous):
  - Both FIFOs are emptied; read and write pointers go to 0.
  - Level_0 = Level_1 = 0, OutValid_0 = OutValid_1 = 0, DemuxOut_0 = DemuxOut_1 = 0. Storage is also cleared, so outputs read 0.
  - InReady = 0 while Reset=0.
  - A reset mid-transfer discards all buffered beats; nothing is replayed afterwards.
- Handshake:
  - A beat transfers when a valid and the matching ready are both 1 on a rising edge.
  - Input side: InReady = Enable & Reset & (Sel ? Level_1 != 2 : Level_0 != 2).
  - InReady is combinational on Sel and may change while InValid is held. The producer must hold DemuxIn and Sel stable until the beat is accepted.
- Push: on an accepted input beat, DemuxIn is written into FIFO[Sel] and Level[Sel] increments.
- Pop: when OutValid_k & OutReady_k, the head of FIFO k is discarded and Level_k decrements.
- Latency:
  - An accepted beat becomes visible at DemuxOut_Sel with OutValid_Sel=1 on the cycle after acceptance.
  - There is no combinational path from input to output.
- FIFO structure:
  - Each FIFO has 2 entries, 1-bit read and write pointers that wrap 1 -> 0, and a 2-bit Level.
  - Full = Level==2; empty = Level==0.
  - DemuxOut_k shows the entry at the read pointer; its value when empty is don't-care.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle (possible only when Level is 1): Level stays 1, both pointers advance, and order is preserved.
  - Push to a full FIFO is impossible because InReady=0. A pop in that cycle frees the slot for the next cycle only; no same-cycle pass-through.
  - Push to one FIFO and pop from the other in the same cycle are fully independent.
- Ordering: strict FIFO order within each output. There is no ordering relation between outputs.
- Enable=0 blocks input only. Buffered beats still drain, and Enable has no effect on output signals.
- Pointer, level and handshake state is reset-only, with no other init path. Data storage updates only on push.

Test Plan:
- Reset, then InValid=0 -> Level_0/1=0, OutValid_0/1=0, InReady=0 while Reset=0; after release with Enable=1, InReady=1.
- Push 0x11 (Sel=0), then 0x22 (Sel=1), OutReady_0/1=1 -> each appears one cycle after acceptance on its own port; Levels return to 0.
- OutReady_0=0; push 0xA1, 0xA2 to Sel=0 -> Level_0=2, InReady=0 for Sel=0 but 1 for Sel=1; push 0xB1 to Sel=1 is accepted; then OutReady_0=1 -> 0xA1 then 0xA2 in order.
- Level_0=1 with head 0xC1; push 0xC2 (Sel=0) and pop in the same cycle -> Level_0 stays 1, next head is 0xC2.
- Enable=0 with InValid=1 -> InReady=0 and no Level change; buffered beats still drain normally.
- Level_0=2, Level_1=1, then pulse Reset=0 mid-cycle -> immediately Level_0/1=0, OutValid_0/1=0; no stale beat after release.
